blake3_compress_core: RTL and testbench

- Parametrised next-generation BLAKE3 compression core that replaces the fixed-mode hash generator.
- Iterative G-function datapath with configurable round count and a configurable number of half-rounds per cycle.
- Generalised inputs: full 64-bit block counter and 8-bit flag byte; a ready/valid/ack handshake provides output backpressure.
- Sits between the miner's chunk/nonce sequencer and the target comparator; one compression per accepted start.

---
 rtl/blake3_compress_core_if.sv | 33 +++
 rtl/blake3_compress_core.sv | 143 ++++++++++++++
 tb/tb_blake3_compress_core.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/blake3_compress_core_if.sv
// Job/result bus between the chunk/nonce sequencer (master) and the BLAKE3 compression core (slave).
// BLAKE3_XOF_OUT_EN adds the extended-output words (digest_xof).
interface blake3_compress_core_if;
  logic             start;
  logic             ready;
  logic [63:0]      counter;
  logic [31:0]      block_len;
  logic [7:0]       flags;
  logic [7:0][31:0] cv;
  logic [15:0][31:0] msg;
  logic             valid;
  logic             ack;
  logic [7:0][31:0] digest;
`ifdef BLAKE3_XOF_OUT_EN
  logic [7:0][31:0] digest_xof;
`endif

  modport master (
    output start, counter, block_len, flags, cv, msg, ack,
`ifdef BLAKE3_XOF_OUT_EN
    input  digest_xof,
`endif
    input  ready, valid, digest
  );

  modport slave (
    input  start, counter, block_len, flags, cv, msg, ack,
`ifdef BLAKE3_XOF_OUT_EN
    output digest_xof,
`endif
    output ready, valid, digest
  );
endinterface

// File: rtl/blake3_compress_core.sv
// Iterative BLAKE3 compression core: 4 or 8 G units per clock, ready/valid/ack result handshake.
// BLAKE3_XOF_OUT_EN: also emit the extended-output words v[i+8] ^ cv[i] on digest_xof.
//
// state | meaning
// IDLE  | waiting for start; ready=1
// RUN   | applying half-steps; final cycle registers the digest
// DONE  | valid held until ack; ack+start chains the next job
module blake3_compress_core #(
  parameter int ROUNDS          = 7,
  parameter int STEPS_PER_CYCLE = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  blake3_compress_core_if.slave bus
);

  generate
    if (ROUNDS < 1 || ROUNDS > 15 || (STEPS_PER_CYCLE != 1 && STEPS_PER_CYCLE != 2)) begin : g_bad_cfg
      $error("blake3_compress_core: illegal ROUNDS/STEPS_PER_CYCLE combination");
    end
  endgenerate

  typedef logic [15:0][31:0] words16_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [4:0] LAST_STEP = 5'(2 * ROUNDS);
  localparam logic [4:0] STEP_INC  = 5'(STEPS_PER_CYCLE);
  localparam logic [3:0] MSG_PERM [16] = '{4'd2, 4'd6, 4'd3, 4'd10, 4'd7, 4'd0, 4'd4, 4'd13,
                                           4'd1, 4'd11, 4'd12, 4'd5, 4'd9, 4'd14, 4'd15, 4'd8};
  localparam logic [3:0][31:0] IV_LO = {32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667};

  state_t           state_q;
  words16_t         v_q, m_q, v_mid, v_nxt, m_nxt, v_init;
  logic [4:0]       step_q;
  logic             valid_q, capture, perm_en;
  logic [7:0][31:0] digest_q;
`ifdef BLAKE3_XOF_OUT_EN
  logic [7:0][31:0] cv_q, digest_xof_q;
`endif

  function automatic logic [127:0] g_fn(input logic [31:0] a_i, b_i, c_i, d_i, x, y);
    logic [31:0] a, b, c, d, t;
    a = a_i + b_i + x;
    t = d_i ^ a;  d = {t[15:0], t[31:16]};
    c = c_i + d;
    t = b_i ^ c;  b = {t[11:0], t[31:12]};
    a = a + b + y;
    t = d ^ a;    d = {t[7:0], t[31:8]};
    c = c + d;
    t = b ^ c;    b = {t[6:0], t[31:7]};
    return {d, c, b, a};
  endfunction

  // The four G units of a step touch disjoint words, so evaluating them in sequence equals parallel.
  function automatic words16_t half_step(input words16_t v, input words16_t m, input logic diag);
    words16_t   r;
    logic [3:0] ia, ib, ic, id, mx;
    r = v;
    for (int i = 0; i < 4; i++) begin
      ia = 4'(i);
      ib = diag ? 4'(4 + ((i + 1) & 3))  : 4'(4 + i);
      ic = diag ? 4'(8 + ((i + 2) & 3))  : 4'(8 + i);
      id = diag ? 4'(12 + ((i + 3) & 3)) : 4'(12 + i);
      mx = diag ? 4'(8 + 2 * i) : 4'(2 * i);
      {r[id], r[ic], r[ib], r[ia]} = g_fn(r[ia], r[ib], r[ic], r[id], m[mx], m[mx + 4'd1]);
    end
    return r;
  endfunction

  function automatic words16_t permute(input words16_t m);
    words16_t r;
    for (int i = 0; i < 16; i++) r[i] = m[MSG_PERM[i]];
    return r;
  endfunction

  always_comb begin
    v_mid   = half_step(v_q, m_q, step_q[0]);
    v_nxt   = v_mid;
    if (STEPS_PER_CYCLE == 2) v_nxt = half_step(v_mid, m_q, 1'b1);
    m_nxt   = permute(m_q);
    perm_en = (STEPS_PER_CYCLE == 2) | step_q[0];
    v_init  = {{24'h0, bus.flags}, bus.block_len, bus.counter[63:32], bus.counter[31:0], IV_LO, bus.cv};
  end

  assign bus.ready  = (state_q == IDLE) | ((state_q == DONE) & bus.ack);
  assign capture    = bus.start & bus.ready;
  assign bus.valid  = valid_q;
  assign bus.digest = digest_q;
`ifdef BLAKE3_XOF_OUT_EN
  assign bus.digest_xof = digest_xof_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      v_q          <= '0;
      m_q          <= '0;
      step_q       <= '0;
      valid_q      <= 1'b0;
      digest_q     <= '0;
`ifdef BLAKE3_XOF_OUT_EN
      cv_q         <= '0;
      digest_xof_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: ;
        RUN: begin
          if (step_q == LAST_STEP) begin
            digest_q     <= v_q[7:0] ^ v_q[15:8];
`ifdef BLAKE3_XOF_OUT_EN
            digest_xof_q <= v_q[15:8] ^ cv_q;
`endif
            valid_q      <= 1'b1;
            state_q      <= DONE;
          end else begin
            v_q    <= v_nxt;
            step_q <= step_q + STEP_INC;
            if (perm_en) m_q <= m_nxt;
          end
        end
        DONE: begin
          if (bus.ack) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // A capture overrides whatever the case chose, covering both IDLE and ack-in-DONE.
      if (capture) begin
        v_q     <= v_init;
        m_q     <= bus.msg;
        step_q  <= '0;
        state_q <= RUN;
`ifdef BLAKE3_XOF_OUT_EN
        cv_q    <= bus.cv;
`endif
      end
    end
  end

endmodule

// File: tb/tb_blake3_compress_core.sv
// Directed bench for blake3_compress_core: known empty-input digest, latency, backpressure,
// back-to-back jobs, asynchronous abort, and counter/flag packing against a reference model.
module tb_blake3_compress_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  blake3_compress_core_if bus1();
  blake3_compress_core_if bus2();

  blake3_compress_core #(.ROUNDS(7), .STEPS_PER_CYCLE(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus1));
  blake3_compress_core #(.ROUNDS(7), .STEPS_PER_CYCLE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  localparam logic [7:0][31:0] IV_CV = {32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
                                        32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667};
  localparam logic [7:0][31:0] EMPTY_DIGEST = {32'h62321fe4, 32'hca939acc, 32'hb712c1ad, 32'hc925cb9b,
                                               32'h49c9dc36, 32'hea4d40a0, 32'ha6a1f9f5, 32'hb94913af};
  localparam logic [3:0] SCHED [16] = '{4'd2, 4'd6, 4'd3, 4'd10, 4'd7, 4'd0, 4'd4, 4'd13,
                                        4'd1, 4'd11, 4'd12, 4'd5, 4'd9, 4'd14, 4'd15, 4'd8};
  localparam logic [3:0] G_IDX [8][4] = '{'{4'd0, 4'd4, 4'd8,  4'd12}, '{4'd1, 4'd5, 4'd9,  4'd13},
                                          '{4'd2, 4'd6, 4'd10, 4'd14}, '{4'd3, 4'd7, 4'd11, 4'd15},
                                          '{4'd0, 4'd5, 4'd10, 4'd15}, '{4'd1, 4'd6, 4'd11, 4'd12},
                                          '{4'd2, 4'd7, 4'd8,  4'd13}, '{4'd3, 4'd4, 4'd9,  4'd14}};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] w, input int n);
    return (w >> n) | (w << (32 - n));
  endfunction

  // Reference compression; returns {xof words, digest words}.
  function automatic logic [511:0] ref_compress(input logic [7:0][31:0] cv, input logic [15:0][31:0] msg,
                                                input logic [63:0] ctr, input logic [31:0] bl,
                                                input logic [7:0] fl);
    logic [15:0][31:0] s, m, mp;
    logic [7:0][31:0]  d, x;
    logic [3:0]        a, b, c, e;
    for (int i = 0; i < 8; i++) s[4'(i)] = cv[3'(i)];
    for (int i = 0; i < 4; i++) s[4'(8 + i)] = IV_CV[3'(i)];
    s[12] = ctr[31:0];
    s[13] = ctr[63:32];
    s[14] = bl;
    s[15] = {24'h0, fl};
    m = msg;
    for (int r = 0; r < 7; r++) begin
      for (int k = 0; k < 8; k++) begin
        a = G_IDX[k][0]; b = G_IDX[k][1]; c = G_IDX[k][2]; e = G_IDX[k][3];
        s[a] = s[a] + s[b] + m[4'(2 * k)];
        s[e] = rotr(s[e] ^ s[a], 16);
        s[c] = s[c] + s[e];
        s[b] = rotr(s[b] ^ s[c], 12);
        s[a] = s[a] + s[b] + m[4'(2 * k + 1)];
        s[e] = rotr(s[e] ^ s[a], 8);
        s[c] = s[c] + s[e];
        s[b] = rotr(s[b] ^ s[c], 7);
      end
      for (int i = 0; i < 16; i++) mp[4'(i)] = m[SCHED[i]];
      m = mp;
    end
    for (int i = 0; i < 8; i++) begin
      d[3'(i)] = s[4'(i)] ^ s[4'(i + 8)];
      x[3'(i)] = s[4'(i + 8)] ^ cv[3'(i)];
    end
    return {x, d};
  endfunction

  task automatic load_job(input logic [255:0] cv, input logic [511:0] msg, input logic [63:0] ctr,
                          input logic [31:0] bl, input logic [7:0] fl);
    bus1.cv = cv; bus1.msg = msg; bus1.counter = ctr; bus1.block_len = bl; bus1.flags = fl;
  endtask

  // Called at the negedge after the capture edge; returns at the negedge where valid is seen.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (bus1.valid !== 1'b1 && cycles < 60) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
  endtask

  logic [511:0]      res_a, res_b;
  logic [15:0][31:0] msg_a, msg_b;
  int lat1, lat2, lat, cnt;

  initial begin
    bus1.start = 0; bus1.ack = 0; load_job('0, '0, '0, '0, '0);
    bus2.start = 0; bus2.ack = 0;
    bus2.cv = '0; bus2.msg = '0; bus2.counter = '0; bus2.block_len = '0; bus2.flags = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 256'(bus1.ready), 256'(1));
    chk("rst_valid", 256'(bus1.valid), 256'(0));
    chk("rst_digest", bus1.digest, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Empty-input hash on both step configurations.
    load_job(IV_CV, '0, '0, 32'd0, 8'h0B);
    bus2.cv = IV_CV; bus2.msg = '0; bus2.counter = '0; bus2.block_len = 32'd0; bus2.flags = 8'h0B;
    bus1.start = 1; bus2.start = 1;
    @(posedge clk);
    @(negedge clk);
    bus1.start = 0; bus2.start = 0;
    chk("run_ready_low", 256'(bus1.ready), 256'(0));
    lat1 = 0; lat2 = 0;
    for (int cyc = 1; cyc <= 40 && (lat1 == 0 || lat2 == 0); cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus1.valid && lat1 == 0) lat1 = cyc;
      if (bus2.valid && lat2 == 0) lat2 = cyc;
    end
    chk("lat_spc1", 256'(lat1), 256'(15));
    chk("lat_spc2", 256'(lat2), 256'(8));
    chk("empty_spc1", bus1.digest, EMPTY_DIGEST);
    chk("empty_spc2", bus2.digest, EMPTY_DIGEST);
`ifdef BLAKE3_XOF_OUT_EN
    res_a = ref_compress(IV_CV, '0, '0, 32'd0, 8'h0B);
    chk("empty_xof", bus1.digest_xof, res_a[511:256]);
`endif
    bus2.ack = 1;
    @(posedge clk);
    @(negedge clk);
    bus2.ack = 0;
    chk("spc2_ack_vld", 256'(bus2.valid), 256'(0));

    // Backpressure: hold ack low for 20 clocks with a stray start that must be ignored.
    for (int k = 0; k < 20; k++) begin
      if (k == 10) begin
        load_job('1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 32'd64, 8'h01);
        bus1.start = 1;
      end
      @(posedge clk);
      @(negedge clk);
      bus1.start = 0;
      chk("bp_valid", 256'(bus1.valid), 256'(1));
      chk("bp_ready", 256'(bus1.ready), 256'(0));
      chk("bp_digest", bus1.digest, EMPTY_DIGEST);
    end
    bus1.ack = 1;
    #1 chk("ack_ready_comb", 256'(bus1.ready), 256'(1));
    @(posedge clk);
    @(negedge clk);
    bus1.ack = 0;
    chk("ack_valid_low", 256'(bus1.valid), 256'(0));
    cnt = 0;
    repeat (20) @(negedge clk) if (bus1.valid) cnt++;
    chk("stray_start_dropped", 256'(cnt), 256'(0));

    // Job A: counter word order and PARENT flag packing; inputs scrambled after capture.
    for (int j = 0; j < 16; j++) msg_a[4'(j)] = 32'(j) * 32'h0101_0101 + 32'h1357_9BDF;
    res_a = ref_compress(IV_CV, msg_a, 64'h0000_0001_0000_0002, 32'd64, 8'h04);
    load_job(IV_CV, msg_a, 64'h0000_0001_0000_0002, 32'd64, 8'h04);
    bus1.start = 1;
    @(posedge clk);
    @(negedge clk);
    bus1.start = 0;
    load_job('0, '1, 64'hDEAD_BEEF_0BAD_F00D, 32'd3, 8'h7F);
    wait_valid(lat);
    chk("lat_job_a", 256'(lat), 256'(15));
    chk("digest_job_a", bus1.digest, res_a[255:0]);
`ifdef BLAKE3_XOF_OUT_EN
    chk("xof_job_a", bus1.digest_xof, res_a[511:256]);
`endif

    // Job B back-to-back with the ack of job A.
    for (int j = 0; j < 16; j++) msg_b[4'(j)] = 32'(j) * 32'h55;
    res_b = ref_compress(IV_CV, msg_b, 64'd0, 32'd64, 8'h01);
    load_job(IV_CV, msg_b, 64'd0, 32'd64, 8'h01);
    bus1.ack = 1; bus1.start = 1;
    #1 chk("b2b_ready", 256'(bus1.ready), 256'(1));
    @(posedge clk);
    @(negedge clk);
    bus1.ack = 0; bus1.start = 0;
    chk("b2b_valid_low", 256'(bus1.valid), 256'(0));
    wait_valid(lat);
    chk("lat_job_b", 256'(lat), 256'(15));
    chk("digest_job_b", bus1.digest, res_b[255:0]);
    bus1.ack = 1;
    @(posedge clk);
    @(negedge clk);
    bus1.ack = 0;

    // Asynchronous abort at clock 7 of a job.
    load_job(IV_CV, '0, '0, 32'd0, 8'h0B);
    bus1.start = 1;
    @(posedge clk);
    @(negedge clk);
    bus1.start = 0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ready", 256'(bus1.ready), 256'(1));
    chk("abort_valid", 256'(bus1.valid), 256'(0));
    chk("abort_digest", bus1.digest, '0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (30) @(negedge clk) if (bus1.valid) cnt++;
    chk("abort_no_valid", 256'(cnt), 256'(0));
    chk("abort_idle_ready", 256'(bus1.ready), 256'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
